// File: rtl/io_input_controller.sv
// Input stage for the CPU IN instruction: synchronises/debounces the enter key and delivers the switch word.
// Optional press timeout is enabled by defining INPUT_TIMEOUT_EN.
module io_input_controller #(
   parameter int DATA_W         = 16,
   parameter int DB_CYCLES      = 50000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clock,
   input  logic              n_reset,
   input  logic              button_n,
   input  logic [DATA_W-1:0] switches,
   input  logic              in_req,
   output logic [DATA_W-1:0] in_data,
   output logic              in_valid,
   output logic              hold,
   output logic              waiting,
   output logic              timed_out
);

   localparam int DB_W = $clog2(DB_CYCLES);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_ARMED      = 2'd1;
   localparam logic [1:0] S_WAIT_PRESS = 2'd2;
   localparam logic [1:0] S_DELIVER    = 2'd3;

   logic              btn_meta;
   logic              btn_s;
   logic [DATA_W-1:0] sw_meta;
   logic [DATA_W-1:0] sw_s;

   logic              db_level;
   logic [DB_W-1:0]   db_cnt;
   logic              press_evt;
   logic              key_pressed;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic              capture;

   // NOTE: the key synchroniser resets to 1 (released) so leaving reset never looks like a press.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         btn_meta <= 1'b1;
         btn_s    <= 1'b1;
         sw_meta  <= '0;
         sw_s     <= '0;
      end else begin
         btn_meta <= button_n;
         btn_s    <= btn_meta;
         sw_meta  <= switches;
         sw_s     <= sw_meta;
      end
   end

   // The level moves only after DB_CYCLES consecutive differing samples; any bounce back restarts the count.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         db_level  <= 1'b1;
         db_cnt    <= '0;
         press_evt <= 1'b0;
      end else begin
         press_evt <= 1'b0;
         if (btn_s == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            db_level  <= btn_s;
            db_cnt    <= '0;
            press_evt <= ~btn_s;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   assign key_pressed = ~db_level;

`ifdef INPUT_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] tmo_cnt;
   logic            tmo_hit;
   logic            timed_out_q;

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         tmo_cnt     <= '0;
         timed_out_q <= 1'b0;
      end else begin
         if (state != S_WAIT_PRESS) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + TO_W'(1);
         end
         timed_out_q <= tmo_hit;
      end
   end

   assign timed_out = timed_out_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timed_out          = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
`ifdef INPUT_TIMEOUT_EN
      tmo_hit   = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (in_req) begin
               state_nxt = key_pressed ? S_ARMED : S_WAIT_PRESS;
            end
         end
         // A key still held from an earlier IN must be released before it can satisfy this one.
         S_ARMED: begin
            if (!in_req) begin
               state_nxt = S_IDLE;
            end else if (!key_pressed) begin
               state_nxt = S_WAIT_PRESS;
            end
         end
         S_WAIT_PRESS: begin
            if (!in_req) begin
               state_nxt = S_IDLE;
            end else if (press_evt) begin
               state_nxt = S_DELIVER;
               capture   = 1'b1;
            end
`ifdef INPUT_TIMEOUT_EN
            else if (tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
               state_nxt = S_DELIVER;
               tmo_hit   = 1'b1;
            end
`endif
         end
         S_DELIVER: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state    <= S_IDLE;
         in_data  <= '0;
         in_valid <= 1'b0;
         waiting  <= 1'b0;
      end else begin
         state    <= state_nxt;
         in_valid <= (state_nxt == S_DELIVER);
         waiting  <= (state_nxt == S_ARMED) || (state_nxt == S_WAIT_PRESS);
         if (capture) begin
            in_data <= sw_s;
         end
      end
   end

   // Dropping hold in the delivery cycle lets the PC advance exactly once per IN.
   assign hold = in_req & (state != S_DELIVER);

endmodule

// File: tb/tb_io_input_controller.sv
// Scoreboard bench for io_input_controller (DB_CYCLES=4, TIMEOUT_CYCLES=20).
module tb_io_input_controller;

   localparam int DATA_W = 16;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              tmo;
      int                cyc;
   } exp_t;

   logic              clock;
   logic              n_reset;
   logic              button_n;
   logic [DATA_W-1:0] switches;
   logic              in_req;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              hold;
   logic              waiting;
   logic              timed_out;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   exp_t sb[$];

   io_input_controller #(
      .DATA_W(DATA_W),
      .DB_CYCLES(4),
      .TIMEOUT_CYCLES(20)
   ) dut (
      .clock(clock),
      .n_reset(n_reset),
      .button_n(button_n),
      .switches(switches),
      .in_req(in_req),
      .in_data(in_data),
      .in_valid(in_valid),
      .hold(hold),
      .waiting(waiting),
      .timed_out(timed_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push_exp(input logic [DATA_W-1:0] data, input logic tmo, input int at_cyc);
      exp_t e;
      e.data = data;
      e.tmo  = tmo;
      e.cyc  = at_cyc;
      sb.push_back(e);
   endtask

   task automatic wait_valid(input int budget);
      logic found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(posedge clock);
         #1;
         if (in_valid) begin
            found = 1'b1;
            check("hold_in_valid_cycle", {31'd0, hold}, 32'd0);
         end
      end
      check("in_valid_within_budget", {31'd0, found}, 32'd1);
   endtask

   // Monitor: every pulse must match the oldest pending expectation.
   always @(negedge clock) begin
      if (n_reset && in_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_in_valid", {31'd0, in_valid}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("in_data", {16'd0, in_data}, {16'd0, e.data});
            check("timed_out", {31'd0, timed_out}, {31'd0, e.tmo});
            check("pulse_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_reset  = 1'b0;
      button_n = 1'b1;
      switches = '0;
      in_req   = 1'b0;
      #22;
      check("rst_in_data", {16'd0, in_data}, 32'd0);
      check("rst_in_valid", {31'd0, in_valid}, 32'd0);
      check("rst_waiting", {31'd0, waiting}, 32'd0);
      check("rst_timed_out", {31'd0, timed_out}, 32'd0);
      check("rst_hold", {31'd0, hold}, 32'd0);
      n_reset = 1'b1;
      tick(2);

      // Basic IN: press and request together, pulse 2+4+1 cycles later.
      switches = 16'h00A5;
      in_req   = 1'b1;
      button_n = 1'b0;
      push_exp(16'h00A5, 1'b0, cyc + 7);
      #1;
      check("basic_hold_same_cycle", {31'd0, hold}, 32'd1);
      tick(1);
      check("basic_waiting", {31'd0, waiting}, 32'd1);
      wait_valid(15);
      in_req = 1'b0;
      tick(3);
      button_n = 1'b1;
      tick(10);

`ifdef INPUT_TIMEOUT_EN
      // Timeout: no press, delivery after 20 WAIT_PRESS cycles with last word.
      in_req = 1'b1;
      push_exp(16'h00A5, 1'b1, cyc + 21);
      wait_valid(30);
      in_req = 1'b0;
      tick(3);
`endif

      // Bounce: toggles every 2 cycles for 12 cycles, request arrives mid-bounce.
      switches = 16'h1234;
      for (int i = 0; i < 6; i++) begin
         button_n = i[0];
         if (i == 3) in_req = 1'b1;
         tick(2);
      end
      button_n = 1'b0;
      push_exp(16'h1234, 1'b0, cyc + 7);
      wait_valid(15);
      in_req = 1'b0;
      tick(3);
      button_n = 1'b1;
      tick(10);

      // Held key: pressed before the request, so a release and new press are needed.
      switches = 16'h5A5A;
      button_n = 1'b0;
      tick(10);
      in_req = 1'b1;
      tick(1);
      check("held_waiting", {31'd0, waiting}, 32'd1);
      tick(4);
      button_n = 1'b1;
      tick(9);
      check("held_still_waiting", {31'd0, waiting}, 32'd1);
      switches = 16'hC3C3;
      button_n = 1'b0;
      push_exp(16'hC3C3, 1'b0, cyc + 7);
      wait_valid(15);
      in_req = 1'b0;
      tick(3);
      button_n = 1'b1;
      tick(10);

      // Abort: request dropped while waiting for a press.
      switches = 16'hFFFF;
      in_req   = 1'b1;
      tick(1);
      check("abort_waiting_hi", {31'd0, waiting}, 32'd1);
      tick(4);
      in_req = 1'b0;
      tick(2);
      check("abort_waiting_lo", {31'd0, waiting}, 32'd0);
      check("abort_in_data", {16'd0, in_data}, 32'h0000C3C3);

      // Idle press: ignored entirely.
      button_n = 1'b0;
      tick(10);
      check("idle_hold", {31'd0, hold}, 32'd0);
      check("idle_waiting", {31'd0, waiting}, 32'd0);
      check("idle_in_data", {16'd0, in_data}, 32'h0000C3C3);
      button_n = 1'b1;
      tick(10);

      // Reset while waiting for a press clears registered outputs at once.
      in_req = 1'b1;
      tick(3);
      n_reset = 1'b0;
      #1;
      check("midrst_in_data", {16'd0, in_data}, 32'd0);
      check("midrst_in_valid", {31'd0, in_valid}, 32'd0);
      check("midrst_waiting", {31'd0, waiting}, 32'd0);
      check("midrst_timed_out", {31'd0, timed_out}, 32'd0);
      in_req = 1'b0;
      tick(2);
      n_reset = 1'b1;
      tick(5);
      check("post_rst_waiting", {31'd0, waiting}, 32'd0);

      tick(5);
      check("pending_expectations", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/io_input_controller.md
Name: io_input_controller

Overview:
- Upstream input stage for the CPU's IN instruction.
- Synchronises and debounces the raw enter key and synchronises the 16 slide switches.
- When the control unit requests input, it holds the PC and waits for a fresh key press. On the press it delivers the captured switch word as a one-cycle valid pulse.
- Replaces the ad-hoc enter-flag path feeding the In Signal MUX.

Parameters:
- DATA_W, 16: switch word width; in_data width.
- DB_CYCLES, 50000: consecutive stable synchronised cycles required to change the debounced key level (minimum 2).
- TIMEOUT_CYCLES, 1000000: WAIT_PRESS cycles before timeout. Used only with INPUT_TIMEOUT_EN.

Ports:
- clock  in  1  system clock; all state on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- button_n  in  1  raw enter key, active low (0 = pressed), asynchronous.
- switches  in  DATA_W  raw slide switches, asynchronous.
- in_req  in  1  control unit executing IN; level, held until in_valid.
- in_data  out  DATA_W  captured switch word; registered.
- in_valid  out  1  one-cycle pulse; in_data valid.
- hold  out  1  stall request to the program counter (combinational).
- waiting  out  1  registered; high in ARMED or WAIT_PRESS (prompt LED).
- timed_out  out  1  registered; high with in_valid when delivery came from timeout.

Behaviour:
- Reset (asynchronous, n_reset=0):
  - state=IDLE, in_data=0, in_valid=0, waiting=0, timed_out=0.
  - Debounced level = released; debounce counter=0.
  - Key synchroniser flops = 1; switch synchroniser flops = 0.
- Synchronisers:
  - Two-flop synchroniser on button_n and on every switch bit.
  - Every later use refers to the synchronised values btn_s and sw_s.
- Debounce:
  - If btn_s equals the debounced level, the counter clears to 0.
  - If btn_s differs, the counter increments. When it reaches DB_CYCLES-1 while btn_s still differs, the debounced level takes btn_s on that edge and the counter clears.
  - A bounce back clears the counter.
  - press_evt is high for one cycle: the cycle after the debounced level changes released->pressed.
- FSM, four states:
  - IDLE: press_evt ignored. If in_req=1: go to ARMED if the debounced key is pressed, else WAIT_PRESS.
  - ARMED: wait for debounced release, then go to WAIT_PRESS. This stops a key held from a previous IN from satisfying the new request.
  - WAIT_PRESS: on press_evt, register in_data<=sw_s (value in the same cycle as press_evt) and go to DELIVER.
  - DELIVER: in_valid=1 for exactly this cycle, then unconditionally IDLE.
  - in_req=0 while in ARMED or WAIT_PRESS aborts to IDLE next edge. No delivery; in_data unchanged.
- Latency: press_evt in cycle N -> in_valid=1 in cycle N+1 -> IDLE in N+2.
- hold = in_req & (state != DELIVER):
  - Asserted in the same cycle in_req first rises.
  - Low in the in_valid cycle, so the PC advances exactly once.
- in_data holds its value between deliveries.
- in_req re-asserted in the cycle right after DELIVER starts a new request. It needs a new press (ARMED if the key is still down).
- Reset mid-operation returns to IDLE immediately. in_valid is never emitted for an interrupted request.

Optional Feature:
- Macro: INPUT_TIMEOUT_EN.
- Defined:
  - A timeout counter clears on entering WAIT_PRESS and increments each WAIT_PRESS cycle.
  - At TIMEOUT_CYCLES-1 without press_evt, go to DELIVER with in_data unchanged (last value) and timed_out=1 during the in_valid cycle.
  - press_evt in the same cycle as the timeout takes priority: normal capture, timed_out=0.
- Undefined: no counter; WAIT_PRESS waits indefinitely; timed_out tied 0.

Test Plan (DB_CYCLES=4, TIMEOUT_CYCLES=20):
- Basic IN: switches=16'h00A5, in_req=1, clean key press held 10 cycles -> hold=1 from the in_req cycle; single in_valid pulse with in_data=16'h00A5 at 2 sync + 4 debounce + 1 cycles after the press; hold=0 in that cycle.
- Bounce: key toggles every 2 cycles for 12 cycles, then stable low -> no in_valid during bouncing; exactly one pulse after 4 stable cycles.
- Held key: key held pressed before in_req -> state ARMED, no in_valid; after release then press -> one pulse carrying sw_s at the new press.
- Abort and reset: in_req dropped in WAIT_PRESS -> IDLE, no pulse, in_data unchanged. n_reset pulse in WAIT_PRESS -> all outputs 0 asynchronously.
- Idle press: key pressed with in_req=0 -> no in_valid, in_data unchanged, hold=0.
- Timeout (INPUT_TIMEOUT_EN): in_req=1, no press -> after 20 WAIT_PRESS cycles in_valid=1, timed_out=1, in_data = previous value (16'h00A5).
